regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter PRIO_MODE, default 0, meaning 0 = round-robin arbitration and 1 = fixed priority to requester 0.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the conflict counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port clk_enable, input, 1 bit: global stall; low freezes all state.
REQ-006 SHALL have ports req0_valid / req1_valid, input, 1 bit each: requester n presents a write.
REQ-007 SHALL have ports req0_reg / req1_reg, input, 5 bits each: destination register index.
REQ-008 SHALL have ports req0_data / req1_data, input, 32 bits each: write data.
REQ-009 SHALL have ports req0_ready / req1_ready, output, 1 bit each: request accepted this cycle.
REQ-010 SHALL have ports write_reg (output, 5 bits), write_enable (output, 1 bit) and write_data (output, 32 bits): the single register-file write port.
REQ-011 SHALL have ports read_reg1 / read_reg2, input, 5 bits each: register-file read addresses to check for hazards.
REQ-012 SHALL have ports hazard_a / hazard_b, output, 1 bit each: the read address matches the write currently on the port.
REQ-013 SHALL have port conflict_count, output, CNT_W bits: saturating count of cycles in which both requesters were valid.

Function
REQ-014 SHALL complete a transfer on reqN when reqN_valid and reqN_ready are both high on a rising clk edge with clk_enable high.
REQ-015 SHALL compute readies combinationally:
- Both readies are 0 when clk_enable is 0.
- When clk_enable is 1, the ready of the single valid requester is 1.
- When both are valid, only the ready of the requester selected by the priority state is 1.
REQ-016 SHALL hold a two-state priority FSM, PRI0 and PRI1, selecting the winner when both requesters are valid.
REQ-017 SHALL, in round-robin mode, transition PRI0 -> PRI1 after a req0 grant and PRI1 -> PRI0 after a req1 grant; with no grant, the state holds.
REQ-018 SHALL, when PRIO_MODE=1, keep the FSM in PRI0 permanently.
REQ-019 SHALL register the accepted request into write_reg/write_data with exactly 1 cycle latency, and drive write_enable=1 in the cycle after acceptance.
REQ-020 SHALL drive write_enable=0 in a cycle following no acceptance; write_reg/write_data then hold their last values.
REQ-021 SHALL, for an accepted request with reg index 0, accept it (ready=1) but drive write_enable=0, so that $zero is never written.
REQ-022 SHALL, when both requesters target the same register in the same cycle, grant only one; the loser stays pending and is written later, so the later write wins.
REQ-023 SHALL drive hazard_a = write_enable AND (write_reg == read_reg1), and likewise hazard_b for read_reg2, combinationally; both are 0 when read_reg is 0.
REQ-024 SHALL increment conflict_count by 1 in each enabled cycle with both valids high, saturating at all-ones.
REQ-025 SHALL, with clk_enable low, hold all registers; write_enable is forced to 0 at the output.
REQ-026 SHALL NOT require requesters to hold data stable beyond the accepting edge.

Reset
REQ-027 SHALL, on reset assertion and independent of clk and clk_enable, reset immediately to: FSM PRI0, write_enable 0, write_reg 0, write_data 0, conflict_count 0.
REQ-028 SHALL, for reset asserted mid-operation, discard any write registered but not yet presented; it is never issued after release.
REQ-029 SHALL hold readies at 0 while reset is high.

Structure
REQ-030 SHALL take from shared package regfile_arb_pkg: typedef reg_idx_t (5 bits), typedef word_t (32 bits), enum pri_state_t {PRI0, PRI1}, and constant ZERO_REG = 0.
REQ-031 SHALL place the two-requester grant logic plus FSM in sub-module rr_arbiter2; the top level holds the output stage, hazard compare and counter.

Verification
REQ-032 SHALL check single request: req0 valid, reg 5, data 0xDEADBEEF -> ready0=1 the same cycle; next cycle write_enable=1, write_reg=5, write_data=0xDEADBEEF.
REQ-033 SHALL check round-robin: both valid for 4 cycles with reg 3 and reg 4 -> grants alternate 0,1,0,1; conflict_count = 4.
REQ-034 SHALL check $zero drop: req1 valid with reg 0, data 0x1234 -> ready1=1; next cycle write_enable=0.
REQ-035 SHALL check stall: clk_enable low for 3 cycles with both valid -> readies 0, write_enable 0, FSM and counter unchanged; resume continues from the prior priority.
REQ-036 SHALL check hazard: write to reg 7 on the port with read_reg1=7 and read_reg2=8 -> hazard_a=1, hazard_b=0.
REQ-037 SHALL check async reset: assert reset between edges right after an acceptance -> write_enable falls immediately; after release no write is issued and conflict_count = 0.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_arb_pkg
//
// Shared types and constants for the register-file write arbiter.
//
//   reg_idx_t    5-bit register index
//   word_t       32-bit register data word
//   pri_state_t  tie-break state of the two-requester arbiter
//   wr_req_t     a selected write request (valid + index + data)
//   ZERO_REG     index of the hard-wired $zero register
//   is_hazard()  read-after-write match helper used by the hazard outputs
// -----------------------------------------------------------------------------
package regfile_arb_pkg;

    localparam int REG_IDX_W = 5;
    localparam int WORD_W    = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [WORD_W-1:0]    word_t;

    // PRI0: requester 0 wins a tie; PRI1: requester 1 wins a tie.
    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_state_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t idx;
        word_t    data;
    } wr_req_t;

    localparam reg_idx_t ZERO_REG = '0;

    // A read port conflicts with the write port when a real write is on the
    // port to the same register. Reads of $zero never conflict.
    function automatic logic is_hazard(input logic     we,
                                       input reg_idx_t wr_idx,
                                       input reg_idx_t rd_idx);
        return we && (rd_idx != ZERO_REG) && (wr_idx == rd_idx);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
//
// Two-requester grant logic with a two-state tie-break FSM.
// Grants are combinational; the tie-break state updates on enabled clock edges.
// In round-robin mode the winner of a transfer hands the tie to the other
// requester; in fixed-priority mode requester 0 always wins a tie.
//
// Parameters
//   PRIO_MODE   0 = round-robin, 1 = fixed priority to requester 0
// Ports
//   clk         clock, rising edge
//   reset       asynchronous active-high reset
//   clk_enable  global stall, low freezes state and suppresses grants
//   req0_valid  requester 0 presents a write
//   req1_valid  requester 1 presents a write
//   grant0      requester 0 is accepted this cycle
//   grant1      requester 1 is accepted this cycle
// -----------------------------------------------------------------------------
module rr_arbiter2
    import regfile_arb_pkg::*;
#(
    parameter int PRIO_MODE = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_enable,
    input  logic req0_valid,
    input  logic req1_valid,
    output logic grant0,
    output logic grant1
);

    pri_state_t state;

    // Reset is included so no grant can leak out while reset is held.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset && clk_enable) begin
            if (req0_valid && req1_valid) begin
                grant0 = (state == PRI0);
                grant1 = (state == PRI1);
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    // Tie-break FSM. Without a grant the state holds.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values; blocking here would create ordering races.
        if (reset) begin
            state <= PRI0;
        end else if (clk_enable) begin
            if (PRIO_MODE == 1) begin
                state <= PRI0;
            end else if (grant0) begin
                state <= PRI1;
            end else if (grant1) begin
                state <= PRI0;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Merges two write requesters onto the single register-file write port.
// An accepted request appears on the write port one cycle after the accepting
// edge. Writes to $zero are accepted but never enabled. Also reports
// read-after-write hazards against the write on the port and counts cycles in
// which both requesters competed.
//
// Parameters
//   PRIO_MODE       0 = round-robin, 1 = fixed priority to requester 0
//   CNT_W           width of the saturating conflict counter
// Ports
//   clk             clock, rising edge
//   reset           asynchronous active-high reset
//   clk_enable      global stall; low freezes all state, forces write_enable 0
//   reqN_valid      requester N presents a write
//   reqN_reg        requester N destination register
//   reqN_data       requester N write data
//   reqN_ready      requester N accepted this cycle (combinational)
//   write_reg       register-file write index
//   write_enable    register-file write enable
//   write_data      register-file write data
//   read_reg1/2     read addresses compared against the write port
//   hazard_a/b      read_reg1/2 matches the write currently on the port
//   conflict_count  saturating count of enabled cycles with both requests valid
// -----------------------------------------------------------------------------
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int PRIO_MODE = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             req0_valid,
    input  reg_idx_t         req0_reg,
    input  word_t            req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  reg_idx_t         req1_reg,
    input  word_t            req1_data,
    output logic             req1_ready,
    output reg_idx_t         write_reg,
    output logic             write_enable,
    output word_t            write_data,
    input  reg_idx_t         read_reg1,
    input  reg_idx_t         read_reg2,
    output logic             hazard_a,
    output logic             hazard_b,
    output logic [CNT_W-1:0] conflict_count
);

    logic grant0;
    logic grant1;

    rr_arbiter2 #(
        .PRIO_MODE (PRIO_MODE)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .grant0     (grant0),
        .grant1     (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Select the granted request; at most one grant is ever high.
    wr_req_t sel_req;

    always_comb begin
        sel_req = '0;
        if (grant0) begin
            sel_req = '{valid: 1'b1, idx: req0_reg, data: req0_data};
        end else if (grant1) begin
            sel_req = '{valid: 1'b1, idx: req1_reg, data: req1_data};
        end
    end

    // Output stage. Index and data are captured at the accepting edge, so
    // requesters may change them right after. They hold when nothing is
    // accepted; only the enable drops.
    logic     we_q;
    reg_idx_t write_reg_q;
    word_t    write_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q         <= 1'b0;
            write_reg_q  <= ZERO_REG;
            write_data_q <= '0;
        end else if (clk_enable) begin
            we_q <= sel_req.valid && (sel_req.idx != ZERO_REG);
            if (sel_req.valid) begin
                write_reg_q  <= sel_req.idx;
                write_data_q <= sel_req.data;
            end
        end
    end

    // A write held across a stall is presented once clk_enable returns.
    assign write_enable = we_q && clk_enable;
    assign write_reg    = write_reg_q;
    assign write_data   = write_data_q;

    assign hazard_a = is_hazard(write_enable, write_reg_q, read_reg1);
    assign hazard_b = is_hazard(write_enable, write_reg_q, read_reg2);

    // Conflict counter: saturates at all-ones instead of wrapping.
    logic [CNT_W-1:0] conflict_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_q <= '0;
        end else if (clk_enable && req0_valid && req1_valid) begin
            if (conflict_q != {CNT_W{1'b1}}) begin
                conflict_q <= conflict_q + CNT_W'(1);
            end
        end
    end

    assign conflict_count = conflict_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Scoreboard bench. The stimulus process predicts readies, the conflict count
// and each register-file write from a transaction-level model and queues the
// expected writes; a separate monitor pops the queue and compares the write
// port and hazard outputs every cycle. A second, fixed-priority instance
// shares the stimulus and has its readies and counter checked.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;
    import regfile_arb_pkg::*;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             clk_enable;
    logic             req0_valid, req1_valid;
    reg_idx_t         req0_reg, req1_reg, read_reg1, read_reg2;
    word_t            req0_data, req1_data;
    logic             req0_ready, req1_ready;
    reg_idx_t         write_reg;
    logic             write_enable;
    word_t            write_data;
    logic             hazard_a, hazard_b;
    logic [CNT_W-1:0] conflict_count;

    logic        fp_ready0, fp_ready1, fp_we, fp_ha, fp_hb;
    reg_idx_t    fp_wreg;
    word_t       fp_wdata;
    logic [15:0] fp_count;

    regfile_write_arbiter #(.PRIO_MODE(0), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_enable     (clk_enable),
        .req0_valid     (req0_valid),
        .req0_reg       (req0_reg),
        .req0_data      (req0_data),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_reg       (req1_reg),
        .req1_data      (req1_data),
        .req1_ready     (req1_ready),
        .write_reg      (write_reg),
        .write_enable   (write_enable),
        .write_data     (write_data),
        .read_reg1      (read_reg1),
        .read_reg2      (read_reg2),
        .hazard_a       (hazard_a),
        .hazard_b       (hazard_b),
        .conflict_count (conflict_count)
    );

    regfile_write_arbiter #(.PRIO_MODE(1), .CNT_W(16)) dut_fp (
        .clk            (clk),
        .reset          (reset),
        .clk_enable     (clk_enable),
        .req0_valid     (req0_valid),
        .req0_reg       (req0_reg),
        .req0_data      (req0_data),
        .req0_ready     (fp_ready0),
        .req1_valid     (req1_valid),
        .req1_reg       (req1_reg),
        .req1_data      (req1_data),
        .req1_ready     (fp_ready1),
        .write_reg      (fp_wreg),
        .write_enable   (fp_we),
        .write_data     (fp_wdata),
        .read_reg1      (read_reg1),
        .read_reg2      (read_reg2),
        .hazard_a       (fp_ha),
        .hazard_b       (fp_hb),
        .conflict_count (fp_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    typedef struct {
        reg_idx_t idx;
        word_t    data;
    } exp_wr_t;

    exp_wr_t exp_q[$];   // writes expected on the port, in order
    int      tie_owner;  // requester that wins the next tie (round-robin)
    int      cnt;        // expected conflict_count (saturating)
    int      cnt_fp;     // expected conflict_count of the fixed-priority copy
    int      checks = 0;
    int      errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Evaluated at the falling edge: checks readies and counters, then
    // advances the model by the coming rising edge.
    task automatic evaluate();
        logic live, e0, e1, f0, f1;
        live = !reset && clk_enable;
        e0 = live && req0_valid && (!req1_valid || tie_owner == 0);
        e1 = live && req1_valid && (!req0_valid || tie_owner == 1);
        f0 = live && req0_valid;
        f1 = live && req1_valid && !req0_valid;
        check("ready0", req0_ready, e0);
        check("ready1", req1_ready, e1);
        check("conflict_count", conflict_count, cnt);
        check("fp_ready0", fp_ready0, f0);
        check("fp_ready1", fp_ready1, f1);
        check("fp_conflict_count", fp_count, cnt_fp);
        if (live) begin
            if (req0_valid && req1_valid) begin
                if (cnt < CNT_MAX) cnt++;
                cnt_fp++;
            end
            if (e0) begin
                if (req0_reg != 0) exp_q.push_back('{req0_reg, req0_data});
                tie_owner = 1;
            end
            if (e1) begin
                if (req1_reg != 0) exp_q.push_back('{req1_reg, req1_data});
                tie_owner = 0;
            end
        end
    endtask

    task automatic cycle(input logic en,
                         input logic v0, input reg_idx_t r0, input word_t d0,
                         input logic v1, input reg_idx_t r1, input word_t d1,
                         input reg_idx_t rd1, input reg_idx_t rd2);
        @(posedge clk);
        #1;
        clk_enable = en;
        req0_valid = v0; req0_reg = r0; req0_data = d0;
        req1_valid = v1; req1_reg = r1; req1_data = d1;
        read_reg1  = rd1; read_reg2 = rd2;
        @(negedge clk);
        evaluate();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    endtask

    // Reset asserted between edges, held for 'hold' cycles, released with
    // idle inputs. Any write still in flight is dropped from the model.
    task automatic async_reset(input int hold);
        @(posedge clk);
        #3;
        reset = 1'b1;
        tie_owner = 0;
        cnt = 0;
        cnt_fp = 0;
        exp_q.delete();
        #1;
        check("async_reset_we", write_enable, 1'b0);
        check("async_reset_count", conflict_count, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            evaluate();
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        clk_enable = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        evaluate();
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_wr_t  cur;
        logic     exp_we;
        reg_idx_t exp_reg;
        forever begin
            @(posedge clk);
            #2;
            exp_we  = 1'b0;
            exp_reg = '0;
            if (reset || !clk_enable) begin
                check("write_enable_idle", write_enable, 1'b0);
            end else if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                exp_we  = 1'b1;
                exp_reg = cur.idx;
                check("write_enable", write_enable, 1'b1);
                check("write_reg", write_reg, cur.idx);
                check("write_data", write_data, cur.data);
            end else begin
                check("write_enable_none", write_enable, 1'b0);
            end
            check("hazard_a", hazard_a, exp_we && read_reg1 != 0 && read_reg1 == exp_reg);
            check("hazard_b", hazard_b, exp_we && read_reg2 != 0 && read_reg2 == exp_reg);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        clk_enable = 1'b1;
        req0_valid = 1'b0; req0_reg = '0; req0_data = '0;
        req1_valid = 1'b0; req1_reg = '0; req1_data = '0;
        read_reg1 = '0; read_reg2 = '0;
        tie_owner = 0;
        cnt = 0;
        cnt_fp = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_we", write_enable, 1'b0);
        check("reset_write_reg", write_reg, 0);
        check("reset_write_data", write_data, 0);
        check("reset_count", conflict_count, 0);
        reset = 1'b0;
        idle(2);

        // Single request on requester 0.
        cycle(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        idle(1);

        // Write to $zero is accepted but never enabled.
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0);
        idle(1);

        // Round-robin: four conflicting cycles.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b1, 5'd3, 32'hA000_0000 + i, 1'b1, 5'd4, 32'hB000_0000 + i, 5'd3, 5'd4);
        idle(1);
        check("rr_conflict_count", conflict_count, 4);

        // Same destination: both writes land, in grant order.
        cycle(1'b1, 1'b1, 5'd6, 32'h1111_1111, 1'b1, 5'd6, 32'h2222_2222, 5'd6, 5'd0);
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h2222_2222, 5'd6, 5'd0);
        idle(1);

        // Stall with both valid, an accepted write held across it.
        cycle(1'b1, 1'b1, 5'd9, 32'h9999_0000, 1'b1, 5'd10, 32'h1010_0000, 5'd9, 5'd10);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b1, 5'd9, 32'h9999_0001, 1'b1, 5'd10, 32'h1010_0001, 5'd9, 5'd10);
        cycle(1'b1, 1'b1, 5'd9, 32'h9999_0002, 1'b1, 5'd10, 32'h1010_0002, 5'd9, 5'd10);
        idle(1);

        // Hazard compare against a write to register 7.
        cycle(1'b1, 1'b1, 5'd7, 32'h7777_7777, 1'b0, 5'd0, 32'h0, 5'd7, 5'd8);
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd8);
        idle(1);

        // Asynchronous reset right after an acceptance.
        cycle(1'b1, 1'b1, 5'd11, 32'hB0B0_B0B0, 1'b1, 5'd12, 32'hC0C0_C0C0, 5'd11, 5'd0);
        async_reset(2);
        idle(3);
        check("post_reset_count", conflict_count, 0);

        // Reset while an accepted write is held by a stall.
        cycle(1'b1, 1'b1, 5'd13, 32'hD0D0_D0D0, 1'b0, 5'd0, 32'h0, 5'd13, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd13, 5'd0);
        async_reset(1);
        idle(2);

        // Randomized traffic; small register range to provoke hazards and
        // same-destination conflicts; long enough to saturate the counter.
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom % 5) != 0,
                  ($urandom % 10) < 6, reg_idx_t'($urandom_range(0, 7)), $urandom,
                  ($urandom % 10) < 6, reg_idx_t'($urandom_range(0, 7)), $urandom,
                  reg_idx_t'($urandom_range(0, 7)), reg_idx_t'($urandom_range(0, 7)));
        end
        idle(3);
        check("saturated_count", conflict_count, CNT_MAX);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
